// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper
// Steps the 4-input breadboard through all 16 input codes. Each code is held
// for SETTLE cycles, the 10 breadboard outputs are then captured, offered to a
// consumer over a valid/ready handshake, and folded into a 16-bit signature.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle sweep request (honoured only when idle)
//   abort      ends a sweep in progress
//   w,x,y,z    breadboard inputs, {w,x,y,z} = current code
//   r[9:0]     breadboard outputs
//   res_valid  captured result presented
//   res_ready  consumer accepts the result
//   res_code   code that produced res_data
//   res_data   captured r
//   signature  running signature of the current or last sweep
//   busy       sweeper not idle
//   done       one-cycle pulse after the last result of a full sweep is taken
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start, breadboard inputs driven 0
// ST_SETTLE  | code driven, counting down the settle time, capture at 1
// ST_PRESENT | result offered, waiting for res_ready
// ST_DONE    | sweep complete, emits the done pulse then returns to idle

module breadboard_sweeper #(
    parameter int SETTLE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic [9:0]  r,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_code,
    output logic [9:0]  res_data,
    output logic [15:0] signature,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PRESENT,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [3:0] code;
    logic [3:0] cnt;
    logic [3:0] drive;

    assign {w, x, y, z} = drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            code      <= '0;
            cnt       <= '0;
            drive     <= '0;
            res_valid <= 1'b0;
            res_code  <= '0;
            res_data  <= '0;
            signature <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drive <= '0;
                    done  <= 1'b0;
                    if (start && !abort) begin
                        signature <= '0;
                        code      <= '0;
                        cnt       <= SETTLE_CNT;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        drive     <= '0;
                    end else if (cnt == 4'd1) begin
                        res_data  <= r;
                        res_code  <= code;
                        signature <= {signature[14:0], signature[15]} ^ {6'b0, r};
                        res_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_PRESENT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        drive     <= '0;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        if (code == 4'd15) begin
                            state <= ST_DONE;
                        end else begin
                            code  <= code + 4'd1;
                            drive <= code + 4'd1;
                            cnt   <= SETTLE_CNT;
                            state <= ST_SETTLE;
                        end
                    end
                end

                ST_DONE: begin
                    // done rises one cycle after entry and busy falls one
                    // cycle after that, so the pulse is seen while still busy.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        drive <= '0;
                    end else if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        drive <= '0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    done      <= 1'b0;
                    drive     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/breadboard_sweeper.md
# breadboard_sweeper

Sequencer that owns the 4-input/10-output combinational breadboard function block. On a start pulse it drives the breadboard inputs through all 16 codes, waits a programmable settle time per code, and captures the 10 outputs. Each captured result goes out through a valid/ready handshake and is folded into a 16-bit running signature. It replaces the free-running delay-based sweep with a clocked, back-pressurable scan that sits between the breadboard and any checker or logger.

## Interface
- SETTLE, default 3: cycles the sweeper holds each code before capture; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  terminates a sweep in progress.
- w, x, y, z  out  1 each  breadboard inputs; {w,x,y,z} = current code, w = MSB.
- r  in  10  breadboard outputs packed, r[i] = ri (r9 is the MSB).
- res_valid  out  1  a captured result is presented.
- res_ready  in  1  the consumer accepts the result.
- res_code  out  4  code that produced res_data.
- res_data  out  10  captured r.
- signature  out  16  running signature of the current or last sweep.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result of a completed sweep is accepted.

## Operation
- States are IDLE, SETTLE, PRESENT and DONE.
- Reset (rst=1 at a clock edge) overrides every other input, including mid-sweep. After reset the state is IDLE, and code, settle counter, w/x/y/z, res_valid, res_code, res_data, signature, busy and done are all 0.
- **IDLE:** w/x/y/z are driven 0.
  - start=1 and abort=0: clear signature, set code=0, load counter with SETTLE, go to SETTLE.
  - start and abort both high: abort wins and the block stays in IDLE.
- **SETTLE:** w/x/y/z = code. The counter decrements each cycle. In the cycle the counter is 1:
  - res_data <= r and res_code <= code;
  - signature <= {signature[14:0], signature[15]} ^ {6'b0, r}, i.e. rotate left by 1, then XOR;
  - go to PRESENT.
- **PRESENT:** res_valid=1. res_code, res_data and w/x/y/z hold steady until the handshake (res_valid & res_ready).
  - Handshake with code<15: code <= code+1, reload counter, go to SETTLE.
  - Handshake with code==15: go to DONE. The code does not wrap.
- **DONE:** done=1 for exactly one cycle, then IDLE. The signature holds its final value until the next accepted start or reset.
- **abort=1** in SETTLE, PRESENT or DONE: next state is IDLE and res_valid drops the next cycle. No done pulse is produced, even from DONE. The signature keeps its partial value.
- start is ignored while busy=1.
- The signature is updated exactly once per code, at capture. Back-pressure never causes a re-capture.

## Timing
- Registered outputs: all outputs change only on the clk edge.
- Start sampled at edge t: busy=1 and {w,x,y,z}=0 from t+1.
- The first capture happens at edge t+SETTLE, so res_valid=1 from t+SETTLE.
- Per code with res_ready held high: SETTLE cycles in SETTLE plus 1 cycle in PRESENT, giving SETTLE+1 cycles per code.
- A full unstalled sweep asserts done in cycle t+16*(SETTLE+1)+1 and returns busy=0 one cycle later.
- Each cycle res_ready is low in PRESENT adds exactly one cycle. Nothing else changes.
- The breadboard is purely combinational, so its inputs are stable for at least SETTLE cycles before r is sampled.

## Test plan
- **Reset mid-sweep:** assert rst during PRESENT of code 5 -> next cycle all outputs are 0 and the state is IDLE. A later start begins at code 0.
- **Basic sweep:** SETTLE=3, res_ready=1, start at cycle 0 ->
  - res_valid first at cycle 3 with res_code=0, res_data=10'h194, signature=16'h0194;
  - code 1 gives res_data=10'h04D and signature=16'h0365;
  - done pulses at cycle 65;
  - all 16 res_data match the behavioural model of the breadboard functions.
- **Back-pressure:** hold res_ready=0 for 7 cycles on code 9 -> res_valid, res_code=9 and res_data stay constant, the signature changes once only, and done is delayed by exactly 7 cycles.
- **Abort:** abort in SETTLE of code 4 -> IDLE next cycle, busy=0, no done, and signature equals the fold of codes 0..3.
- **Start ignored / simultaneous:** start during PRESENT -> no effect. start and abort together in IDLE -> stays IDLE with busy=0.
- **SETTLE=1 corner:** unstalled sweep -> 2 cycles per code, done at cycle 33, and results identical to the SETTLE=3 run.
